// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, clock-select codes and sizing helper for the PLL lock sequencer
package pll_seq_pkg;
    typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, RUN, GATE, SETTLE, FAULT} state_t;
    localparam logic [1:0] SEL_12M     = 2'd0;
    localparam logic [1:0] SEL_13M3    = 2'd1;
    localparam logic [1:0] SEL_14M3    = 2'd2;
    localparam logic [1:0] SEL_ILLEGAL = 2'd3;
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (rst) {q, meta} <= 2'b00;
        else     {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset/lock qualification with retry, and glitch-safe clock-mux select changes
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int         RST_CYCLES   = 16,
    parameter int         LOCK_STABLE  = 1024,
    parameter int         LOCK_TIMEOUT = 500000,
    parameter int         MAX_RETRY    = 3,
    parameter int         GUARD_CYCLES = 8,
    parameter logic [1:0] DEFAULT_SEL  = SEL_12M
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    input  logic       sel_req_valid,
    input  logic [1:0] sel_req_idx,
    output logic       sel_req_ready,
    output logic       sel_req_err,
    output logic [1:0] clk_sel,
    output logic       clk_gate_en,
    output logic       core_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt
);
    localparam int CW = $clog2(max2(max2(RST_CYCLES, LOCK_STABLE), max2(LOCK_TIMEOUT, 2 * GUARD_CYCLES)) + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [SW-1:0] stable, stable_d;
    logic [1:0]    target, target_d, clk_sel_d, retry_d;
    logic          lock_s, accept, err_d, run_d, clocked;

    sync_2ff u_sync (.clk(refclk), .rst(rst), .d(pll_locked), .q(lock_s));

    assign accept  = sel_req_valid & sel_req_ready;
    assign clocked = (state == RUN) || (state == GATE) || (state == SETTLE);

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 1'b1;
        stable_d  = '0;
        target_d  = target;
        clk_sel_d = clk_sel;
        retry_d   = retry_cnt;
        err_d     = 1'b0;
        case (state)
            PLL_RST: begin
                if (cnt == CW'(RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                stable_d = lock_s ? stable + 1'b1 : '0;
                // Lock completion is checked first so it wins over a same-cycle timeout.
                if (stable == SW'(LOCK_STABLE)) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    stable_d = '0;
                    retry_d  = '0;
                end else if (cnt == CW'(LOCK_TIMEOUT)) begin
                    cnt_d    = '0;
                    stable_d = '0;
                    if (retry_cnt == 2'(MAX_RETRY - 1)) state_d = FAULT;
                    else begin
                        retry_d = retry_cnt + 1'b1;
                        state_d = PLL_RST;
                    end
                end
            end
            RUN: begin
                cnt_d = '0;
                if (accept && sel_req_idx == SEL_ILLEGAL) err_d = 1'b1;
                else if (accept && sel_req_idx != clk_sel) begin
                    target_d = sel_req_idx;
                    state_d  = GATE;
                end
            end
            GATE: begin
                if (cnt == CW'(GUARD_CYCLES - 1)) begin
                    clk_sel_d = target;
                    state_d   = SETTLE;
                    cnt_d     = '0;
                end
            end
            SETTLE: begin
                if (cnt == CW'(GUARD_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            FAULT:   cnt_d = '0;
            default: state_d = PLL_RST;
        endcase
        // Lock loss overrides everything: a pending switch is dropped and the mux stays put.
        if (clocked && !lock_s) begin
            state_d   = PLL_RST;
            cnt_d     = '0;
            clk_sel_d = clk_sel;
            err_d     = 1'b0;
        end
        run_d = (state_d == RUN);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= PLL_RST;
            cnt           <= '0;
            stable        <= '0;
            target        <= DEFAULT_SEL;
            clk_sel       <= DEFAULT_SEL;
            retry_cnt     <= '0;
            pll_rst       <= 1'b1;
            clk_gate_en   <= 1'b0;
            core_rst      <= 1'b1;
            ready         <= 1'b0;
            fault         <= 1'b0;
            sel_req_ready <= 1'b0;
            sel_req_err   <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            stable        <= stable_d;
            target        <= target_d;
            clk_sel       <= clk_sel_d;
            retry_cnt     <= retry_d;
            pll_rst       <= (state_d == PLL_RST) || (state_d == FAULT);
            clk_gate_en   <= run_d;
            core_rst      <= !run_d;
            ready         <= run_d;
            fault         <= (state_d == FAULT);
            sel_req_ready <= run_d;
            sel_req_err   <= err_d;
        end
    end
endmodule
